// File: rtl/contador_8bits.sv
`default_nettype none
//--------------------------------------------------------------------
// contador_8bits: prescaled 8-bit up/down counter with free-run,
// reload-on-match and stop-on-match modes.            Rev 1.0
//--------------------------------------------------------------------
module contador_8bits #(
   parameter int PRESCALE_DIV = 50_000_000,
   parameter int PRESC_W      = 26
) (
   input  logic       iClk,
   input  logic       iReset,
   input  logic       iEnable,
   input  logic       iUpDown,
   input  logic       iLoad,
   input  logic [7:0] ivLoadValue,
   input  logic       iClear,
   input  logic [1:0] ivMode,
   input  logic       iCompareFlag,
   output logic [7:0] ovCuenta,
   output logic       oTick,
   output logic       oWrap,
   output logic       oStopped
);

   localparam logic [PRESC_W-1:0] PRESC_MAX   = PRESC_W'(PRESCALE_DIV - 1);
   localparam logic [1:0]         MODE_RELOAD = 2'b01;
   localparam logic [1:0]         MODE_STOP   = 2'b10;

   typedef enum logic [0:0] {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } state_t;

   state_t             state_q,  state_d;
   logic [PRESC_W-1:0] presc_q,  presc_d;
   logic [7:0]         cuenta_q, cuenta_d;
   logic               tick_q,   tick_d;
   logic               wrap_q,   wrap_d;

   logic               step;
   logic [7:0]         cuenta_nat;
   logic               nat_wrap;

   always_comb begin
      step       = (state_q == ST_RUN) && iEnable && (presc_q == PRESC_MAX);
      cuenta_nat = iUpDown ? (cuenta_q + 8'd1) : (cuenta_q - 8'd1);
      nat_wrap   = iUpDown ? (cuenta_q == 8'hFF) : (cuenta_q == 8'h00);
   end

   // Load and clear discard a coincident step entirely: no tick, no wrap.
   always_comb begin
      state_d  = state_q;
      presc_d  = presc_q;
      cuenta_d = cuenta_q;
      tick_d   = 1'b0;
      wrap_d   = 1'b0;
      if (iLoad) begin
         cuenta_d = ivLoadValue;
         presc_d  = '0;
         state_d  = ST_RUN;
      end else if (iClear) begin
         cuenta_d = 8'h00;
         presc_d  = '0;
         state_d  = ST_RUN;
      end else if (step) begin
         presc_d = '0;
         tick_d  = 1'b1;
         if ((ivMode == MODE_RELOAD) && iCompareFlag) begin
            cuenta_d = ivLoadValue;
         end else if ((ivMode == MODE_STOP) && iCompareFlag) begin
            state_d = ST_HALT;
         end else begin
            cuenta_d = cuenta_nat;
            wrap_d   = nat_wrap;
         end
      end else if ((state_q == ST_RUN) && iEnable) begin
         presc_d = presc_q + PRESC_W'(1);
      end
   end

   always_ff @(posedge iClk) begin
      if (iReset) begin
         state_q  <= ST_RUN;
         presc_q  <= '0;
         cuenta_q <= 8'h00;
         tick_q   <= 1'b0;
         wrap_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         presc_q  <= presc_d;
         cuenta_q <= cuenta_d;
         tick_q   <= tick_d;
         wrap_q   <= wrap_d;
      end
   end

   assign ovCuenta = cuenta_q;
   assign oTick    = tick_q;
   assign oWrap    = wrap_q;
   assign oStopped = (state_q == ST_HALT);

endmodule
`default_nettype wire

// File: tb/tb_contador_8bits.sv
`default_nettype none
//--------------------------------------------------------------------
// tb_contador_8bits: scoreboard bench for contador_8bits with a
// registered comparator model in the feedback loop.   Rev 1.0
//--------------------------------------------------------------------
module tb_contador_8bits;

   localparam int DIV = 4;

   logic       clk = 1'b0;
   logic       iReset = 1'b1;
   logic       iEnable = 1'b0;
   logic       iUpDown = 1'b1;
   logic       iLoad = 1'b0;
   logic [7:0] ivLoadValue = 8'h00;
   logic       iClear = 1'b0;
   logic [1:0] ivMode = 2'b00;
   logic       cmp_flag = 1'b0;
   logic [7:0] cmp_val = 8'h05;
   logic [7:0] ovCuenta;
   logic       oTick;
   logic       oWrap;
   logic       oStopped;

   contador_8bits #(.PRESCALE_DIV(DIV), .PRESC_W(4)) dut (
      .iClk        (clk),
      .iReset      (iReset),
      .iEnable     (iEnable),
      .iUpDown     (iUpDown),
      .iLoad       (iLoad),
      .ivLoadValue (ivLoadValue),
      .iClear      (iClear),
      .ivMode      (ivMode),
      .iCompareFlag(cmp_flag),
      .ovCuenta    (ovCuenta),
      .oTick       (oTick),
      .oWrap       (oWrap),
      .oStopped    (oStopped)
   );

   always #5 clk = ~clk;

   // Registered equality comparator closing the loop.
   always @(posedge clk) cmp_flag <= (ovCuenta == cmp_val);

   typedef struct {
      logic [7:0] cnt;
      logic       wrap;
   } exp_t;

   exp_t q[$];
   exp_t e;
   int   total = 0;
   int   bad = 0;
   int   m_cnt = 0;
   int   m_phase = 0;
   bit   m_halt = 1'b0;
   bit   mon_on = 1'b0;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endfunction

   // Reference: counts enabled clocks; every DIV-th one is a step.
   function automatic void model_edge();
      int   nxt;
      exp_t x;
      if (iReset) begin
         m_cnt = 0; m_phase = 0; m_halt = 1'b0;
      end else if (iLoad) begin
         m_cnt = int'(ivLoadValue); m_phase = 0; m_halt = 1'b0;
      end else if (iClear) begin
         m_cnt = 0; m_phase = 0; m_halt = 1'b0;
      end else if (!m_halt && iEnable) begin
         m_phase++;
         if (m_phase == DIV) begin
            m_phase = 0;
            x.wrap = 1'b0;
            if (ivMode == 2'b01 && m_cnt == int'(cmp_val)) begin
               m_cnt = int'(ivLoadValue);
            end else if (ivMode == 2'b10 && m_cnt == int'(cmp_val)) begin
               m_halt = 1'b1;
            end else begin
               nxt    = iUpDown ? m_cnt + 1 : m_cnt - 1;
               x.wrap = (nxt == 256) || (nxt == -1);
               m_cnt  = (nxt + 256) % 256;
            end
            x.cnt = m_cnt[7:0];
            q.push_back(x);
         end
      end
   endfunction

   always @(negedge clk) begin
      if (mon_on) begin
         chk("count", {24'd0, ovCuenta}, m_cnt);
         chk("stopped", {31'd0, oStopped}, {31'd0, m_halt});
         chk("tick", {31'd0, oTick}, (q.size() != 0) ? 32'd1 : 32'd0);
         if (q.size() != 0) begin
            e = q.pop_front();
            chk("tick_count", {24'd0, ovCuenta}, {24'd0, e.cnt});
            chk("wrap", {31'd0, oWrap}, {31'd0, e.wrap});
         end else begin
            chk("wrap_idle", {31'd0, oWrap}, 32'd0);
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      model_edge();
      #2;
   endtask

   task automatic run(int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   initial begin
      logic [7:0] snap;
      cyc();
      mon_on = 1'b1;
      chk("rst_count", {24'd0, ovCuenta}, 32'd0);
      chk("rst_tick", {31'd0, oTick}, 32'd0);
      chk("rst_stopped", {31'd0, oStopped}, 32'd0);
      iReset = 1'b0; iEnable = 1'b1; iUpDown = 1'b1; ivMode = 2'b00;

      // Free-run up: first step on the 4th edge, then wrap after 256 steps.
      run(3);
      chk("edge3_count", {24'd0, ovCuenta}, 32'd0);
      cyc();
      chk("edge4_count", {24'd0, ovCuenta}, 32'd1);
      chk("edge4_tick", {31'd0, oTick}, 32'd1);
      run(DIV * 255);
      chk("up_wrap_count", {24'd0, ovCuenta}, 32'd0);
      chk("up_wrap_flag", {31'd0, oWrap}, 32'd1);

      // Free-run down through 0x00 -> 0xFF.
      iLoad = 1'b1; ivLoadValue = 8'h02; iUpDown = 1'b0;
      cyc();
      iLoad = 1'b0;
      chk("load_count", {24'd0, ovCuenta}, 32'h02);
      chk("load_notick", {31'd0, oTick}, 32'd0);
      run(DIV * 3);
      chk("down_wrap_count", {24'd0, ovCuenta}, 32'hFF);
      chk("down_wrap_flag", {31'd0, oWrap}, 32'd1);

      // Reload-on-match: 0..5 then back to 0.
      iLoad = 1'b1; ivLoadValue = 8'h00; cmp_val = 8'h05; ivMode = 2'b01; iUpDown = 1'b1;
      cyc();
      iLoad = 1'b0;
      run(DIV * 6);
      chk("reload_period", {24'd0, ovCuenta}, 32'd0);
      run(DIV * 8);

      // Stop-on-match at 0x0A, idle in HALT, then clear.
      iLoad = 1'b1; ivLoadValue = 8'h00; cmp_val = 8'h0A; ivMode = 2'b10;
      cyc();
      iLoad = 1'b0;
      run(DIV * 11);
      chk("halt_count", {24'd0, ovCuenta}, 32'h0A);
      chk("halt_flag", {31'd0, oStopped}, 32'd1);
      run(40);
      chk("halt_idle_count", {24'd0, ovCuenta}, 32'h0A);
      iClear = 1'b1;
      cyc();
      iClear = 1'b0;
      chk("clear_count", {24'd0, ovCuenta}, 32'd0);
      chk("clear_stopped", {31'd0, oStopped}, 32'd0);
      run(DIV - 1);
      chk("clear_hold", {24'd0, ovCuenta}, 32'd0);
      cyc();
      chk("clear_step", {24'd0, ovCuenta}, 32'd1);

      // Enable gating with the prescaler at 2.
      ivMode = 2'b00;
      for (int i = 0; i < 8 && m_phase != 2; i++) cyc();
      chk("gate_phase", m_phase, 32'd2);
      iEnable = 1'b0;
      run(10);
      iEnable = 1'b1;
      snap = ovCuenta;
      cyc();
      chk("gate_hold", {24'd0, ovCuenta}, {24'd0, snap});
      cyc();
      chk("gate_step", {24'd0, ovCuenta}, {24'd0, snap + 8'd1});

      // Load and clear together on a step edge.
      for (int i = 0; i < 8 && m_phase != DIV - 1; i++) cyc();
      iLoad = 1'b1; iClear = 1'b1; ivLoadValue = 8'h80;
      cyc();
      iLoad = 1'b0; iClear = 1'b0;
      chk("prio_count", {24'd0, ovCuenta}, 32'h80);
      chk("prio_notick", {31'd0, oTick}, 32'd0);

      // Reset mid-count.
      run(6);
      iReset = 1'b1;
      cyc();
      iReset = 1'b0;
      chk("midrst_count", {24'd0, ovCuenta}, 32'd0);
      chk("midrst_tick", {31'd0, oTick}, 32'd0);
      chk("midrst_wrap", {31'd0, oWrap}, 32'd0);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         int r;
         r           = int'($urandom_range(0, 199));
         iReset      = (r == 0);
         iLoad       = (r >= 1 && r <= 4);
         iClear      = (r >= 5 && r <= 6);
         iEnable     = ($urandom_range(0, 9) != 0);
         iUpDown     = ($urandom_range(0, 3) != 0);
         ivMode      = 2'($urandom_range(0, 3));
         ivLoadValue = 8'($urandom_range(0, 255));
         if (iLoad)
            cmp_val = iUpDown ? ivLoadValue + 8'($urandom_range(0, 5))
                              : ivLoadValue - 8'($urandom_range(0, 5));
         cyc();
      end
      iReset = 1'b0; iLoad = 1'b0; iClear = 1'b0;
      run(2);
      chk("queue_empty", q.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/contador_8bits.md
# contador_8bits

Prescaled 8-bit up/down counter that produces the count consumed by the registered equality comparator in the 8-bit counter design. It feeds `ivCuenta` directly and receives that comparator's `oCompareFlag` back as `iCompareFlag`. The flag drives free-run, reload-on-match or stop-on-match behaviour. A parameterised prescaler sets the count rate.

## Interface

- PRESCALE_DIV, 50_000_000: clocks per count step; legal range 2..2^PRESC_W.
- PRESC_W, 26: prescaler register width.
- iClk  in  1  system clock; all logic on rising edge.
- iReset  in  1  reset iReset, synchronous, active-high.
- iEnable  in  1  1 = prescaler runs; 0 = prescaler and count hold.
- iUpDown  in  1  1 = count up, 0 = count down.
- iLoad  in  1  synchronous load; `ovCuenta` ← `ivLoadValue`.
- ivLoadValue  in  8  load and reload value.
- iClear  in  1  synchronous clear; `ovCuenta` ← 0x00, leaves HALT.
- ivMode  in  2  00 free-run, 01 reload-on-match, 10 stop-on-match, 11 treated as 00.
- iCompareFlag  in  1  registered match flag from the comparator.
- ovCuenta  out  8  current count (registered).
- oTick  out  1  one-cycle pulse, high in the cycle after each step edge.
- oWrap  out  1  one-cycle pulse on natural wrap.
- oStopped  out  1  high while in HALT.

## Operation

- **State machine:** RUN and HALT. Reset → RUN.
- **Prescaler register P, in RUN with iEnable=1:**
  - Increments each clock.
  - At P == PRESCALE_DIV-1, asserts internal `step` and P ← 0.
- **P holds when:** iEnable=0, or state is HALT.
- **On `step`, by ivMode:**
  - 00 / 11: count ± 1, modulo 256.
  - 01: if iCompareFlag=1, count ← ivLoadValue; else count ± 1.
  - 10: if iCompareFlag=1, count holds, state → HALT, oStopped ← 1; else count ± 1.
- **oWrap ← 1** only for a natural ± 1 step 0xFF→0x00 (up) or 0x00→0xFF (down). Loads, reloads and clears never assert oWrap.
- **oTick ← `step`**, registered.
- **Priority, highest first:**
  1. iReset
  2. iLoad
  3. iClear
  4. `step` actions
- **iLoad:** count ← ivLoadValue, P ← 0, state → RUN, oStopped ← 0. No oTick or oWrap.
- **iClear:** count ← 0x00, P ← 0, state → RUN, oStopped ← 0.
- **HALT:** exits only via iLoad, iClear or iReset. iEnable and ivMode changes are ignored in HALT.
- **iUpDown and ivMode:** sampled only at `step`; changes between steps have no side effects.

## Timing

- **Reset values:** ovCuenta=0x00, oTick=0, oWrap=0, oStopped=0, P=0, state=RUN. All take effect at the first edge with iReset=1.
- **Step period:** with iEnable held 1 from reset release, the first `step` edge is the PRESCALE_DIV-th edge after release. Later steps follow every PRESCALE_DIV clocks.
- **Count latency:** ovCuenta changes at the `step` edge. oTick and oWrap are high for exactly the following cycle.
- **Compare loop:** the comparator adds one register stage, so iCompareFlag reflects the count from one clock earlier.
  - PRESCALE_DIV ≥ 2 guarantees the count has been stable ≥ 1 cycle at every `step`, so the sampled flag is valid.
  - PRESCALE_DIV < 2 is illegal.
- **iLoad/iClear:** take effect at the edge where they are sampled high. They override a coincident `step`, which is discarded (count not stepped, no oTick).
- **Reset mid-count or in HALT:** all outputs and state return to reset values at the next edge.

## Test plan

Benches use PRESCALE_DIV=4 with a cycle-accurate comparator model.

- **Free-run up wrap:** reset, iEnable=1, iUpDown=1, mode 00. Count reaches 0x01 at edge 4 and increments every 4 clocks. On 0xFF→0x00, oWrap=1 for one cycle, aligned with oTick.
- **Free-run down wrap:** iLoad with 0x02, iUpDown=0. Count goes 0x02→0x01→0x00→0xFF at 4-clock spacing. oWrap pulses only on 0x00→0xFF; no oWrap or oTick on the load.
- **Reload-on-match:** mode 01, compare value 0x05, ivLoadValue=0x00, up. Count sequence is 0,1,2,3,4,5,0,1…, a 6-step period with no oWrap.
- **Stop-on-match:** mode 10, compare value 0x0A. At the step after 0x0A, count holds 0x0A and oStopped=1. After 40 idle clocks, nothing changes. A single iClear cycle gives count=0x00, oStopped=0, and next step 0x01 four clocks later.
- **Enable gating:** drop iEnable for 10 clocks when P=2. On re-enable, the next step occurs 2 clocks later.
- **Priority:** assert iLoad=1 (value 0x80) and iClear=1 on a `step` edge. Count=0x80, no oTick.
- **Reset mid-operation:** assert iReset for 1 cycle mid-count. All outputs are 0 at the next edge.
